// File: rtl/multi_channel_sensor_sequencer.sv
// -----------------------------------------------------------------------------
// multi_channel_sensor_sequencer
//
// Sequences up to NUM_CHANNELS sensor front ends that share one ADC. For each
// channel selected in the captured mask (ascending order) it enables the
// sensor and ADC, waits SETTLE_CYCLES, then takes 2^k samples
// (read pulse + wait for conversion). It averages them by a truncating right
// shift and presents one result per channel.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_start, i_abort           sequence control (abort wins over start)
//   i_channel_mask             channels to measure, captured on start
//   i_channel_config           per-channel sensor config, captured on start
//   i_oversample_log2          k, captured on start, clamped to MAX_OS_LOG2
//   o_busy, o_done             not-idle flag, end-of-sequence pulse
//   o_result_*                 one-cycle result per measured channel
//   o_sens_config/enable/read  sensor pad controls for the active channel
//   o_adc_enable, o_adc_read   ADC controls
//   i_adc_conversion_complete  ADC sample ready, i_adc_value is its data
// -----------------------------------------------------------------------------
module multi_channel_sensor_sequencer #(
  parameter int NUM_CHANNELS   = 4,
  parameter int CONFIG_WIDTH   = 3,
  parameter int ADC_WIDTH      = 16,
  parameter int MAX_OS_LOG2    = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int K_W  = (MAX_OS_LOG2 > 0) ? $clog2(MAX_OS_LOG2 + 1) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_start,
  input  logic                                 i_abort,
  input  logic [NUM_CHANNELS-1:0]              i_channel_mask,
  input  logic [NUM_CHANNELS*CONFIG_WIDTH-1:0] i_channel_config,
  input  logic [K_W-1:0]                       i_oversample_log2,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_result_valid,
  output logic [CH_W-1:0]                      o_result_channel,
  output logic [ADC_WIDTH-1:0]                 o_result_value,
  output logic                                 o_result_timeout,
  output logic [CONFIG_WIDTH-1:0]              o_sens_config,
  output logic [NUM_CHANNELS-1:0]              o_sens_enable,
  output logic [NUM_CHANNELS-1:0]              o_sens_read,
  output logic                                 o_adc_enable,
  output logic                                 o_adc_read,
  input  logic                                 i_adc_conversion_complete,
  input  logic [ADC_WIDTH-1:0]                 i_adc_value
);

  localparam int ACC_W = ADC_WIDTH + MAX_OS_LOG2;
  localparam int CNT_W = MAX_OS_LOG2 + 1;
  localparam int ST_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int WT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_NEXT, S_SETTLE, S_READ, S_CONVERT, S_RESULT
  } state_t;

  state_t                           r_state;
  state_t                           w_next_state;
  logic [NUM_CHANNELS-1:0]          r_pending;
  logic [NUM_CHANNELS*CONFIG_WIDTH-1:0] r_config;
  logic [K_W-1:0]                   r_k;
  logic [CH_W-1:0]                  r_ch;
  logic [ST_W-1:0]                  r_settle_cnt;
  logic [WT_W-1:0]                  r_wait_cnt;
  logic [CNT_W-1:0]                 r_sample_cnt;
  logic [ACC_W-1:0]                 r_acc;
  logic                             r_timeout;
  logic                             r_done;

  logic                             w_found;
  logic [CH_W-1:0]                  w_sel;
  logic                             w_settle_done;
  logic                             w_timeout_hit;
  logic                             w_sample_end;
  logic                             w_last_sample;
  logic [CNT_W-1:0]                 w_target;
  logic [CONFIG_WIDTH-1:0]          w_cfg;

  // k above the supported maximum is silently limited.
  function automatic logic [K_W-1:0] clamp_k(input logic [K_W-1:0] k);
    if (k > K_W'(MAX_OS_LOG2)) return K_W'(MAX_OS_LOG2);
    return k;
  endfunction

  // Average of 2^k samples: plain truncating shift, no rounding.
  function automatic logic [ADC_WIDTH-1:0] avg_trunc(input logic [ACC_W-1:0] acc,
                                                     input logic [K_W-1:0]   k);
    return ADC_WIDTH'(acc >> k);
  endfunction

  // Lowest pending channel wins: scan downward so the last hit is the lowest.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_found = 1'b1;
        w_sel   = CH_W'(i);
      end
    end
  end

  always_comb begin
    w_cfg = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (r_ch == CH_W'(i)) w_cfg = r_config[i*CONFIG_WIDTH +: CONFIG_WIDTH];
    end
  end

  assign w_settle_done = (r_settle_cnt == ST_W'(SETTLE_CYCLES - 1));
  assign w_timeout_hit = (r_wait_cnt == WT_W'(TIMEOUT_CYCLES - 1));
  assign w_sample_end  = i_adc_conversion_complete || w_timeout_hit;
  assign w_target      = CNT_W'(1) << r_k;
  assign w_last_sample = ((r_sample_cnt + CNT_W'(1)) == w_target);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (i_start && !i_abort) w_next_state = S_NEXT;
      S_NEXT:    w_next_state = w_found ? S_SETTLE : S_IDLE;
      S_SETTLE:  if (w_settle_done) w_next_state = S_READ;
      S_READ:    w_next_state = S_CONVERT;
      S_CONVERT: if (w_sample_end) w_next_state = w_last_sample ? S_RESULT : S_READ;
      S_RESULT:  w_next_state = S_NEXT;
      default:   w_next_state = S_IDLE;
    endcase
    if (r_state != S_IDLE && i_abort) w_next_state = S_IDLE;
  end

  // Sequence bookkeeping: capture, channel selection, counters, accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= '0;
      r_config     <= '0;
      r_k          <= '0;
      r_ch         <= '0;
      r_settle_cnt <= '0;
      r_wait_cnt   <= '0;
      r_sample_cnt <= '0;
      r_acc        <= '0;
      r_timeout    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= (r_state == S_NEXT) && !w_found && !i_abort;
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            r_pending <= i_channel_mask;
            r_config  <= i_channel_config;
            r_k       <= clamp_k(i_oversample_log2);
          end
        end
        S_NEXT: begin
          if (w_found) begin
            r_ch             <= w_sel;
            r_pending[w_sel] <= 1'b0;
            r_settle_cnt     <= '0;
            r_sample_cnt     <= '0;
            r_acc            <= '0;
            r_timeout        <= 1'b0;
          end
        end
        S_SETTLE: r_settle_cnt <= r_settle_cnt + ST_W'(1);
        S_READ:   r_wait_cnt   <= '0;
        S_CONVERT: begin
          if (i_adc_conversion_complete) begin
            r_acc        <= r_acc + ACC_W'(i_adc_value);
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
          end else if (w_timeout_hit) begin
            // A lost conversion contributes zero but flags the channel.
            r_timeout    <= 1'b1;
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
          end else begin
            r_wait_cnt   <= r_wait_cnt + WT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches an output
  always_comb begin
    o_busy           = (r_state != S_IDLE);
    o_done           = r_done;
    o_result_valid   = 1'b0;
    o_result_channel = '0;
    o_result_value   = '0;
    o_result_timeout = 1'b0;
    o_sens_config    = '0;
    o_sens_enable    = '0;
    o_sens_read      = '0;
    o_adc_enable     = 1'b0;
    o_adc_read       = 1'b0;
    if (r_state == S_SETTLE || r_state == S_READ ||
        r_state == S_CONVERT || r_state == S_RESULT) begin
      o_sens_enable = NUM_CHANNELS'(1) << r_ch;
      o_sens_config = w_cfg;
      o_adc_enable  = 1'b1;
    end
    if (r_state == S_READ) begin
      o_sens_read = NUM_CHANNELS'(1) << r_ch;
      o_adc_read  = 1'b1;
    end
    if (r_state == S_RESULT) begin
      o_result_valid   = 1'b1;
      o_result_channel = r_ch;
      o_result_value   = avg_trunc(r_acc, r_k);
      o_result_timeout = r_timeout;
    end
  end

endmodule

// File: tb/tb_multi_channel_sensor_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for multi_channel_sensor_sequencer.
// A behavioural ADC answers each read from a per-channel sample table. Each
// sequence pushes the expected per-channel results (sum of completed samples
// shifted by k, timeout if any sample is lost) into a queue. A monitor pops the
// queue on every result_valid and also tracks read counts, enable exclusivity
// and settle time.
// -----------------------------------------------------------------------------
module tb_multi_channel_sensor_sequencer;

  localparam int NCH    = 4;
  localparam int CW     = 3;
  localparam int AW     = 16;
  localparam int MOS    = 4;
  localparam int SETTLE = 16;
  localparam int TMO    = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort;
  logic [NCH-1:0]    mask_in;
  logic [NCH*CW-1:0] cfg_in;
  logic [2:0]    k_in;
  logic          adc_cc;
  logic [AW-1:0] adc_val;
  logic          busy, done, rv, rto, aen, ard;
  logic [1:0]    rch;
  logic [AW-1:0] rval;
  logic [CW-1:0] scfg;
  logic [NCH-1:0] sen, srd;

  always #5 clk = ~clk;

  multi_channel_sensor_sequencer #(
    .NUM_CHANNELS(NCH), .CONFIG_WIDTH(CW), .ADC_WIDTH(AW), .MAX_OS_LOG2(MOS),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_channel_mask(mask_in), .i_channel_config(cfg_in), .i_oversample_log2(k_in),
    .o_busy(busy), .o_done(done), .o_result_valid(rv), .o_result_channel(rch),
    .o_result_value(rval), .o_result_timeout(rto), .o_sens_config(scfg),
    .o_sens_enable(sen), .o_sens_read(srd), .o_adc_enable(aen), .o_adc_read(ard),
    .i_adc_conversion_complete(adc_cc), .i_adc_value(adc_val)
  );

  typedef struct { int ch; int val; bit to; int cfg; } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [AW-1:0] s_val [NCH][16];
  int  s_dly [NCH][16];           // cycles from read to completion, 0 = never
  int  s_idx [NCH];
  int  rd_cnt [NCH];
  int  done_cnt, done_cyc;
  bit  en_bad, settle_bad, rd_bad;
  logic [NCH-1:0] cur_mask;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    chk(name, {busy, done, rv, rch, rval, rto, scfg, sen, srd, aen, ard}, 0);
  endtask

  function automatic int oh_idx(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference model: one channel's expected result from its sample table.
  task automatic push_chan(input int ch, input int keff, input logic [NCH*CW-1:0] cfg);
    exp_t e;
    int sum = 0;
    bit to = 0;
    for (int i = 0; i < (1 << keff); i++) begin
      if (s_dly[ch][i] > 0) sum += int'(s_val[ch][i]);
      else to = 1;
    end
    e.ch = ch; e.val = sum >> keff; e.to = to; e.cfg = int'((cfg >> (CW*ch)) & 7);
    exp_q.push_back(e);
  endtask

  task automatic fill_random();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 16; i++) begin
        s_val[c][i] = AW'($urandom);
        s_dly[c][i] = $urandom_range(1, 6);
      end
  endtask

  task automatic clear_stats(input logic [NCH-1:0] m);
    for (int c = 0; c < NCH; c++) begin rd_cnt[c] = 0; s_idx[c] = 0; end
    done_cnt = 0; en_bad = 0; settle_bad = 0; rd_bad = 0; cur_mask = m;
  endtask

  task automatic run_seq(input logic [NCH-1:0] m, input int kin,
                         input logic [NCH*CW-1:0] cfg, input string tag);
    int keff = (kin > MOS) ? MOS : kin;
    int scyc, waitc;
    for (int c = 0; c < NCH; c++) if (m[c]) push_chan(c, keff, cfg);
    clear_stats(m);
    @(negedge clk);
    start = 1; mask_in = m; cfg_in = cfg; k_in = 3'(kin); scyc = cyc;
    @(negedge clk);
    start = 0; mask_in = NCH'($urandom); cfg_in = (NCH*CW)'($urandom); k_in = 3'($urandom);
    if (m != 0) begin
      repeat (4) @(negedge clk);
      start = 1; mask_in = NCH'($urandom);
      @(negedge clk);
      start = 0;
    end
    waitc = 0;
    while (done_cnt == 0 && waitc < 20000) begin @(negedge clk); waitc++; end
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_missing_results"}, exp_q.size(), 0);
    chk({tag, "_busy_after"}, busy, 0);
    for (int c = 0; c < NCH; c++) chk({tag, "_reads"}, rd_cnt[c], m[c] ? (1 << keff) : 0);
    chk({tag, "_enable_excl"}, en_bad, 0);
    chk({tag, "_settle"}, settle_bad, 0);
    chk({tag, "_read_sync"}, rd_bad, 0);
    if (m == 0) chk({tag, "_done_latency"}, done_cyc - scyc, 2);
    exp_q.delete();
  endtask

  // Behavioural ADC: answers each read after the table delay. It also
  // throws garbage completions into some READ cycles, which must be ignored.
  initial begin
    int cd, ch;
    logic [AW-1:0] pv;
    cd = 0; pv = '0; adc_cc = 0; adc_val = '0;
    forever begin
      @(negedge clk);
      adc_cc = 0; adc_val = AW'($urandom);
      if (!rst_n || !busy) cd = 0;
      else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin adc_cc = 1; adc_val = pv; end
        end
        if (ard) begin
          ch = oh_idx(srd);
          if (s_idx[ch] < 16) begin
            pv = s_val[ch][s_idx[ch]];
            cd = s_dly[ch][s_idx[ch]];
            s_idx[ch]++;
          end
          if ($urandom_range(0, 1) == 1) adc_cc = 1;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [NCH-1:0] prev_en;
    int enc;
    bit seen_rd;
    exp_t e;
    prev_en = '0; enc = 0; seen_rd = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin prev_en = '0; continue; end
      if (rv) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got ch %0d value %0h, none expected", rch, rval);
        end else begin
          e = exp_q.pop_front();
          chk("result_channel", rch, e.ch);
          chk("result_value", rval, e.val);
          chk("result_timeout", rto, e.to);
          chk("result_config", scfg, e.cfg);
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (srd != 0) rd_cnt[oh_idx(srd)]++;
      if (ard != (srd != 0)) rd_bad = 1;
      if (sen != 0) begin
        if ($countones(sen) != 1 || (sen & ~cur_mask) != 0 || !aen) en_bad = 1;
        if (prev_en != 0 && prev_en != sen) en_bad = 1;
        if (prev_en == 0) begin enc = 0; seen_rd = 0; end
        if (!seen_rd) begin
          if (srd != 0) begin
            seen_rd = 1;
            if (enc != SETTLE) settle_bad = 1;
          end else enc++;
        end
      end
      prev_en = sen;
    end
  end

  initial begin
    logic [NCH*CW-1:0] cfg;
    int w;
    rst_n = 0; start = 0; abort = 0; mask_in = '0; cfg_in = '0; k_in = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    rst_n = 1;
    repeat (2) @(negedge clk);
    check_zero("idle_outputs");

    // Two channels, single sample each
    fill_random();
    s_val[0][0] = 16'h1234; s_dly[0][0] = 3;
    s_val[2][0] = 16'hABCD; s_dly[2][0] = 3;
    run_seq(4'b0101, 0, (NCH*CW)'($urandom), "mask0101");

    // k=2 average with truncation: (10+11+12+13)>>2 = 11
    fill_random();
    for (int i = 0; i < 4; i++) s_val[1][i] = AW'(10 + i);
    run_seq(4'b0010, 2, (NCH*CW)'($urandom), "k2_trunc");

    // Full-scale samples with k=7 clamped to 4
    fill_random();
    for (int i = 0; i < 16; i++) s_val[0][i] = 16'hFFFF;
    run_seq(4'b0001, 7, (NCH*CW)'($urandom), "fullscale_clamp");

    // One sample times out on ch3
    fill_random();
    s_dly[3][0] = 2; s_dly[3][1] = 0;
    run_seq(4'b1000, 1, (NCH*CW)'($urandom), "timeout_partial");

    // Every sample on ch3 times out, ch0 normal before it
    fill_random();
    s_dly[3][0] = 0; s_dly[3][1] = 0;
    run_seq(4'b1001, 1, (NCH*CW)'($urandom), "timeout_full");

    // Randomized sequences
    for (int n = 0; n < 6; n++) begin
      fill_random();
      run_seq(NCH'($urandom), $urandom_range(0, 7), (NCH*CW)'($urandom), "random");
    end

    // Abort and start together in IDLE: abort wins
    @(negedge clk); start = 1; abort = 1; mask_in = 4'b1111;
    @(negedge clk); start = 0; abort = 0;
    chk("abort_beats_start", busy, 0);

    // Abort during ch2 conversion
    fill_random();
    s_dly[2][0] = 6;
    cfg = (NCH*CW)'($urandom);
    push_chan(0, 0, cfg); push_chan(1, 0, cfg);
    clear_stats(4'b0111);
    @(negedge clk); start = 1; mask_in = 4'b0111; cfg_in = cfg; k_in = 0;
    @(negedge clk); start = 0;
    w = 0;
    while (!srd[2] && w < 5000) begin @(negedge clk); w++; end
    chk("abort_reached_ch2", w < 5000, 1);
    @(negedge clk); abort = 1;
    @(negedge clk); abort = 0;
    check_zero("abort_outputs");
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_results", exp_q.size(), 0);
    exp_q.delete();

    // Empty mask right after abort
    run_seq(4'b0000, 0, (NCH*CW)'($urandom), "mask0");

    // Asynchronous reset in the middle of SETTLE
    fill_random();
    clear_stats(4'b0110);
    @(negedge clk); start = 1; mask_in = 4'b0110; cfg_in = (NCH*CW)'($urandom); k_in = 1;
    @(negedge clk); start = 0;
    w = 0;
    while (sen == 0 && w < 100) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    chk("rst_in_settle", sen != 0 && srd == 0, 1);
    @(posedge clk); #2 rst_n = 0;
    #1 check_zero("async_reset_outputs");
    @(negedge clk); rst_n = 1;
    repeat (5) @(negedge clk);
    chk("after_reset_busy", busy, 0);
    chk("after_reset_done", done_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_channel_sensor_sequencer.md
# multi_channel_sensor_sequencer

Parametrised successor to the single-sensor ADC control path. It drives NUM_CHANNELS sensor front ends that share one ADC, sequencing enable, settle, read and convert for each channel selected in a mask. Each channel is oversampled by 2^k (k programmable, averaged by truncating shift) and yields one result per channel. The block sits between the application adapter (command and result side) and the sensor/ADC pads, in the 13.56 MHz recovered-clock domain.

## Interface
Parameters:
- NUM_CHANNELS, 4: number of sensor channels, 1..8.
- CONFIG_WIDTH, 3: per-channel sens_config width.
- ADC_WIDTH, 16: adc_value width.
- MAX_OS_LOG2, 4: maximum oversample exponent; accumulator is ADC_WIDTH+MAX_OS_LOG2 bits.
- SETTLE_CYCLES, 16: cycles between enable and first read, ≥1.
- TIMEOUT_CYCLES, 1024: maximum wait for adc_conversion_complete.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin a sequence. Honoured only in IDLE.
- abort, input, 1: terminate the sequence immediately.
- channel_mask, input, NUM_CHANNELS: channels to measure. Captured on start.
- channel_config, input, NUM_CHANNELS*CONFIG_WIDTH: per-channel config. Captured on start.
- oversample_log2, input, $clog2(MAX_OS_LOG2+1): k, captured on start. Clamped to MAX_OS_LOG2.
- busy, output, 1: high whenever the state is not IDLE.
- done, output, 1: one-cycle pulse when a sequence completes normally.
- result_valid, output, 1: one-cycle pulse per measured channel.
- result_channel, output, $clog2(NUM_CHANNELS) (minimum 1): channel of the current result.
- result_value, output, ADC_WIDTH: averaged value.
- result_timeout, output, 1: qualifies result_valid. Set when any sample of that channel timed out.
- sens_config, output, CONFIG_WIDTH: config of the active channel. 0 when idle.
- sens_enable, output, NUM_CHANNELS: one-hot enable of the active channel.
- sens_read, output, NUM_CHANNELS: one-hot read pulse.
- adc_enable, output, 1; adc_read, output, 1; adc_conversion_complete, input, 1; adc_value, input, ADC_WIDTH.

## Operation
- Reset values: all outputs 0. State is IDLE.
- States: IDLE, SETTLE, READ, CONVERT, RESULT, NEXT.
- IDLE → NEXT on start. Mask, config and k are registered on that edge.
- NEXT: select the lowest unserviced set bit of the captured mask, ascending order. If a bit is found, go to SETTLE. If none remain, pulse done and go to IDLE.
- SETTLE: sens_enable[ch], adc_enable and sens_config are driven. Count SETTLE_CYCLES, then go to READ. The accumulator and sample count are cleared on entry.
- READ: one cycle with sens_read[ch] and adc_read high, then go to CONVERT.
- CONVERT: wait for adc_conversion_complete.
  - When it is seen, add adc_value (zero-extended) to the accumulator.
  - A timeout occurs after TIMEOUT_CYCLES cycles without it. On timeout, add 0 and set the channel's timeout flag.
  - If sample count < 2^k, go back to READ. Otherwise go to RESULT.
- RESULT: one cycle. result_valid=1 and result_value = accumulator >> k, truncated (no rounding). result_channel and result_timeout are also driven. Drop sens_enable, adc_enable and sens_config on exit. Then go to NEXT.
- adc_conversion_complete is ignored outside CONVERT, including during the READ cycle.
- abort, in any non-IDLE state: go to IDLE on the next edge. All enables, reads and result_valid go low. done is not pulsed. Any partial result is discarded.
- If abort and start are both high in IDLE, abort wins: the block stays IDLE.
- start while busy is ignored. Mask, config and k changes mid-sequence have no effect.
- An all-zero mask gives busy for 1 cycle (NEXT), then a done pulse, and no results.
- Accumulator arithmetic cannot overflow: 2^MAX_OS_LOG2 × (2^ADC_WIDTH−1) fits in the accumulator width.

## Timing
- Start sampled at edge 0. Edge 1: NEXT. Edge 2: SETTLE, so enables are high from edge 2.
- First read pulse: SETTLE_CYCLES cycles after enable rises.
- Per sample: 1 READ cycle plus the conversion wait, then the CONVERT exit cycle.
- RESULT follows the cycle that accepted the last conversion.
- Per-channel latency = 1 (NEXT) + SETTLE_CYCLES + 2^k × (1 + conversion wait + 1) + 1 (RESULT).
- Enables of consecutive channels never overlap. There is at least the NEXT cycle with all enables low between channels.
- done asserts on the cycle after the last RESULT's NEXT. busy falls on the same edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Mask 4'b0101, k=0, ADC returns 0x1234 (ch0) and 0xABCD (ch2) 3 cycles after each read → two results (ch0 0x1234, then ch2 0xABCD). Then done. ch1 and ch3 enables never assert.
- Mask 4'b0010, k=2, samples 10, 11, 12, 13 → one result, ch1, value 11 (46>>2, truncated). Exactly 4 read pulses are seen.
- Mask 4'b0001, k=4, adc_value 0xFFFF for all samples → result 0xFFFF (no overflow). k=7 on input is clamped to 4, giving 16 reads.
- Conversion never completes on ch3, k=1, TIMEOUT_CYCLES=1024 → result_timeout=1. Value is the completed sample >>1 or 0. The sequence continues and done pulses.
- Abort asserted in CONVERT of ch2 → all outputs low next cycle, no done, busy=0. A subsequent start with mask 0 → done after 2 cycles with no results.
- rst_n asserted mid-SETTLE → outputs 0 immediately (asynchronous). A start pulsed while busy → ignored, checked by counting results.
